// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the FIFO slice: default word and address widths, and a
// helper that turns an address width into a storage depth.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 4;
   localparam int DEFAULT_ADDR_WIDTH = 3;

   // Number of storage entries addressed by an aw-bit address.
   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/fifo_if.sv
// -----------------------------------------------------------------------------
// fifo_if
// Producer/consumer handshake bundle for fifo_ctrl.
//   in_valid/in_ready/in_data    : enqueue side
//   out_valid/out_ready/out_data : dequeue side
//   count/full/empty             : status, driven by the FIFO
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer may hold or drop valid freely; the
// FIFO's ready/valid outputs depend only on registered state.
// Modports: master = bench/user side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  empty;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count, full, empty
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count, full, empty
   );

endinterface

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// 1-write / 1-read register array, no reset.
//   clk : write clock
//   we  : write enable, wa : write address, wd : write data (synchronous)
//   ra  : read address, rd : read data (asynchronous)
// -----------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wa,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic [ADDR_WIDTH-1:0] ra,
   output logic [DATA_WIDTH-1:0] rd
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wa] <= wd;
      end
   end

   assign rd = mem_q[ra];

endmodule

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Synchronous show-ahead FIFO controller in front of a register array.
//   clk : clock, rst : synchronous active-high reset
//   bus : fifo_if slave modport (enqueue/dequeue handshakes and status)
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; count is simply their difference.
// -----------------------------------------------------------------------------
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic  clk,
   input  logic  rst,
   fifo_if.slave bus
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic                  empty, full;
   logic                  push, pop;
   logic [DATA_WIDTH-1:0] mem_rd;

   // Status is a function of the registered pointers only.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

   assign push = bus.in_valid  && !full;
   assign pop  = bus.out_ready && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk (clk),
      .we  (push),
      .wa  (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wd  (bus.in_data),
      .ra  (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd  (mem_rd)
   );

   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.count     = wr_ptr_q - rd_ptr_q;
   // Storage is never cleared, so hide whatever the head slot holds when empty.
   assign bus.out_data  = empty ? '0 : mem_rd;

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
// Directed bench for fifo_ctrl. A queue model tracks the expected contents;
// a compare process checks all outputs every falling edge, and the directed
// sequence adds literal checks at the interesting points.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

   localparam int DW    = 4;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic clk;
   logic rst;

   int n_checks;
   int n_fail;

   fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [DW-1:0] exp_q[$];
   bit            model_ok = 1'b0;

   always @(posedge clk) begin
      bit do_push, do_pop;
      if (rst) begin
         exp_q.delete();
         model_ok = 1'b1;
      end else begin
         do_push = bus.in_valid  && (exp_q.size() < DEPTH);
         do_pop  = bus.out_ready && (exp_q.size() > 0);
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(bus.in_data);
      end
   end

   // ---------------- compare ----------------
   always @(negedge clk) begin
      int sz;
      if (model_ok) begin
         sz = exp_q.size();
         chk("count",     32'(bus.count),     32'(sz));
         chk("empty",     32'(bus.empty),     32'(sz == 0));
         chk("full",      32'(bus.full),      32'(sz == DEPTH));
         chk("in_ready",  32'(bus.in_ready),  32'(sz != DEPTH));
         chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
         chk("out_data",  32'(bus.out_data),  (sz == 0) ? 32'd0 : 32'(exp_q[0]));
      end
   end

   // ---------------- driver ----------------
   task automatic cyc(input logic r, input logic iv, input logic [DW-1:0] d, input logic orr);
      rst           = r;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = orr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset then idle
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("rst_count",     32'(bus.count),     32'd0);
      chk("rst_empty",     32'(bus.empty),     32'd1);
      chk("rst_full",      32'(bus.full),      32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);

      // Fill to full, then a rejected 9th push
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 1, DW'(i), 0);
         chk("fill_count", 32'(bus.count), 32'(i));
      end
      chk("fill_full",     32'(bus.full),     32'd1);
      chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
      cyc(0, 1, 4'd9, 0);
      chk("push9_count", 32'(bus.count),    32'd8);
      chk("push9_head",  32'(bus.out_data), 32'd1);

      // Drain in order
      for (int i = 1; i <= 8; i++) begin
         chk("drain_data", 32'(bus.out_data), 32'(i));
         cyc(0, 0, 0, 1);
      end
      chk("drain_empty", 32'(bus.empty),    32'd1);
      chk("drain_data0", 32'(bus.out_data), 32'd0);

      // Wrap-around: 5 in / 5 out, then A..F
      for (int i = 1; i <= 5; i++) cyc(0, 1, DW'(i), 0);
      for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 1);
      chk("wrap_empty", 32'(bus.empty), 32'd1);
      for (int i = 10; i <= 15; i++) begin
         cyc(0, 1, DW'(i), 0);
         chk("wrap_fill_count", 32'(bus.count), 32'(i - 9));
      end
      for (int i = 10; i <= 15; i++) begin
         chk("wrap_data", 32'(bus.out_data), 32'(i));
         cyc(0, 0, 0, 1);
         chk("wrap_drain_count", 32'(bus.count), 32'(15 - i));
      end

      // Simultaneous push/pop with 3 stored
      cyc(0, 1, 4'd1, 0);
      cyc(0, 1, 4'd2, 0);
      cyc(0, 1, 4'd3, 0);
      cyc(0, 1, 4'd7, 1);
      chk("both_mid_count", 32'(bus.count),    32'd3);
      chk("both_mid_head",  32'(bus.out_data), 32'd2);

      // Fill (2,3,7 + 5 more), then push/pop when full
      for (int i = 4; i <= 8; i++) cyc(0, 1, DW'(i), 0);
      chk("both_full_pre", 32'(bus.full), 32'd1);
      cyc(0, 1, 4'hf, 1);
      chk("both_full_count", 32'(bus.count),    32'd7);
      chk("both_full_head",  32'(bus.out_data), 32'd3);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1);
      chk("both_full_drained", 32'(bus.empty), 32'd1);

      // Push/pop when empty: only the push fires
      cyc(0, 1, 4'd5, 1);
      chk("both_empty_count", 32'(bus.count),     32'd1);
      chk("both_empty_valid", 32'(bus.out_valid), 32'd1);
      chk("both_empty_data",  32'(bus.out_data),  32'd5);

      // Reset mid-operation with a push pending
      cyc(0, 1, 4'd8, 0);
      cyc(0, 1, 4'd9, 0);
      cyc(0, 1, 4'd10, 0);
      chk("pre_rst_count", 32'(bus.count), 32'd4);
      cyc(1, 1, 4'd6, 0);
      chk("mid_rst_count", 32'(bus.count),    32'd0);
      chk("mid_rst_empty", 32'(bus.empty),    32'd1);
      chk("mid_rst_data",  32'(bus.out_data), 32'd0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("post_rst_count", 32'(bus.count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous first-in/first-out queue that owns the write and read addressing of a small register-array store. Producers push words through a valid/ready handshake, and consumers pop them in arrival order through a second valid/ready handshake. It sits directly in front of the register storage, generating write enable, write address and read address, and it forwards the head-of-queue word to the consumer. It is the buffering stage between the lab's input logic and its display/processing logic.

## Interface
Parameters:
- DATA_WIDTH, 4: width of one stored word
- ADDR_WIDTH, 3: storage address width; DEPTH = 2**ADDR_WIDTH entries (8 by default)

Ports:
- clk  input  1  the only clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers in_data this cycle
- in_ready  output  1  FIFO can accept a word; equals !full
- in_data  input  DATA_WIDTH  word to enqueue
- out_valid  output  1  head word is available; equals !empty
- out_ready  input  1  consumer takes the head word this cycle
- out_data  output  DATA_WIDTH  head-of-queue word; 0 when empty
- count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Enqueue fires when in_valid && in_ready. in_data is written at wr_ptr, and wr_ptr advances by 1.
- Dequeue fires when out_valid && out_ready. rd_ptr advances by 1, and the next entry becomes the head.
- Pointers are ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits address the storage, and the MSB is a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) && (MSBs differ).
  - count = wr_ptr − rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Wrap-around: an increment from DEPTH−1 returns the low bits to 0 and toggles the MSB. No special case is needed.
- Both handshakes in the same cycle while non-empty and non-full: both fire, and count is unchanged.
- Full with both requested: only the dequeue fires (in_ready=0). The word is accepted on a later cycle.
- Empty with both requested: only the enqueue fires (out_valid=0). There is no bypass, so the word appears at out_data the next cycle.
- in_data is ignored when in_valid=0. out_ready is ignored when empty.
- The storage is not cleared by reset. Stale contents are never visible because out_data is forced to 0 when empty.

## Timing
- Reset values after any edge with rst=1:
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0, in_ready=1, out_valid=0, out_data=0
- rst has priority over every handshake on the same edge. Words pending at reset are discarded.
- Write latency: a word enqueued at edge N is visible on out_data, with out_valid=1, after edge N if the FIFO was empty.
- out_data is combinational from storage[rd_ptr] (show-ahead). It changes only after an edge that moves rd_ptr, or after an edge that writes into an empty FIFO.
- All status outputs (full, empty, count, in_ready, out_valid) are derived from registered pointers only, so there is no combinational path from in_valid or out_ready to them.
- Throughput: one enqueue and one dequeue per cycle, sustained.

## Structure
- Shared package fifo_pkg: default DATA_WIDTH / ADDR_WIDTH constants and a DEPTH helper function. No typedefs are required.
- Sub-module fifo_mem: a 1-write/1-read register array.
  - Write is synchronous on clk with we/wa/wd.
  - Read is asynchronous on ra/rd.
  - No reset.
- fifo_ctrl contains the pointer registers, status logic, handshake gating and the out_data zero-mux.

## Test plan
- Reset then idle: hold rst=1 for 2 cycles, then release → count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0.
- Fill to full: enqueue 1,2,…,8 on consecutive cycles → count reaches 8, full=1, in_ready=0. A 9th push of 9 is not accepted, and count stays 8.
- Drain in order: from the full state, hold out_ready=1 for 8 cycles → out_data reads 1..8 in order, then empty=1 and out_data=0.
- Wrap-around: enqueue 5 words and dequeue 5, then enqueue A,B,C,D,E,F → pointers wrap, and dequeue order is A..F with count correct throughout.
- Simultaneous push/pop:
  - Holding 3 words, push 7 and pop together → count stays 3, and the head advances.
  - When full, push and pop together → only the pop fires, and count=7.
  - When empty, push and pop together → only the push fires, and count=1.
- Reset mid-operation: with 4 words stored, assert rst together with in_valid=1, in_data=6 → next cycle count=0, empty=1, out_data=0. The 6 is not stored.
